// File: rtl/cic_dac_out.sv
// CIC output stage: round/shift/saturate, FIFO, MSB-first SPI DAC serializer.
// Optional CIC_DAC_SATCNT_EN adds a saturating 16-bit sat_cnt output.
module cic_dac_out #(
  parameter int Win    = 16,
  parameter int Wg     = 22,
  parameter int Wout   = 16,
  parameter int SHIFT  = 6,
  parameter int DEPTH  = 4,
  parameter int CLKDIV = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [Win+Wg-1:0] i_data,
  input  logic                    val_in,
  output logic                    sclk,
  output logic                    cs_n,
  output logic                    sdo,
  output logic                    busy,
  output logic                    sat,
  output logic                    ovf
`ifdef CIC_DAC_SATCNT_EN
  ,
  output logic [15:0]             sat_cnt
`endif
);

  localparam int W  = Win + Wg;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(Wout);
  localparam int DW = $clog2(2 * CLKDIV + 1);

  localparam logic signed [W:0] ONE  = 1;
  localparam logic signed [W:0] RND  =
    (SHIFT > 0) ? (ONE <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [W:0] MAXV = (ONE <<< (Wout - 1)) - ONE;
  localparam logic signed [W:0] MINV = -MAXV - ONE;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  // One extra bit so the rounding add cannot wrap.
  logic signed [W:0] ext_d, sum_d, r_d;
  logic              hi_d, lo_d;
  logic [Wout-1:0]   word_d;

  assign ext_d = {i_data[W-1], i_data};
  assign sum_d = ext_d + RND;
  assign r_d   = sum_d >>> SHIFT;
  assign hi_d  = r_d > MAXV;
  assign lo_d  = r_d < MINV;

  always_comb begin
    word_d = r_d[Wout-1:0];
    if (hi_d)      word_d = {1'b0, {(Wout-1){1'b1}}};
    else if (lo_d) word_d = {1'b1, {(Wout-1){1'b0}}};
  end

  logic            s1_val_q, sat_q;
  logic [Wout-1:0] s1_word_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_val_q <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      s1_val_q <= val_in;
      sat_q    <= val_in & (hi_d | lo_d);
    end
    if (val_in) s1_word_q <= word_d;
  end

  logic [Wout-1:0] mem_q [DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   cnt_q;
  logic            ovf_q;
  state_t          state_q;
  logic            push, pop, full, wr_en;

  assign push  = s1_val_q;
  assign pop   = (state_q == S_IDLE) && (cnt_q != '0);
  assign full  = cnt_q == CW'(DEPTH);
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= s1_word_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (wr_en) wr_q <= wr_q + AW'(1);
      if (pop)   rd_q <= rd_q + AW'(1);
      if (push && full && !pop) ovf_q <= 1'b1;
      if (wr_en && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (!wr_en && pop) cnt_q <= cnt_q - CW'(1);
    end
  end

  logic            sclk_q, cs_n_q, sdo_q;
  logic [Wout-1:0] sr_q;
  logic [BW-1:0]   bit_q;
  logic [DW-1:0]   div_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      sdo_q   <= 1'b0;
      sr_q    <= '0;
      bit_q   <= '0;
      div_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (pop) begin
            sr_q    <= mem_q[rd_q];
            sdo_q   <= mem_q[rd_q][Wout-1];
            cs_n_q  <= 1'b0;
            sclk_q  <= 1'b0;
            bit_q   <= BW'(Wout - 1);
            div_q   <= '0;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (div_q == DW'(CLKDIV - 1)) begin
            div_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              sclk_q <= 1'b0;
              if (bit_q == '0) begin
                cs_n_q  <= 1'b1;
                sdo_q   <= 1'b0;
                state_q <= S_GAP;
              end else begin
                bit_q <= bit_q - BW'(1);
                sr_q  <= sr_q << 1;
                sdo_q <= sr_q[Wout-2];
              end
            end
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        S_GAP: begin
          if (div_q == DW'(2 * CLKDIV - 1)) begin
            div_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef CIC_DAC_SATCNT_EN
  logic [15:0] sat_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                              sat_cnt_q <= '0;
    else if (sat_q && sat_cnt_q != '1)    sat_cnt_q <= sat_cnt_q + 16'd1;
  end

  assign sat_cnt = sat_cnt_q;
`endif

  assign sclk = sclk_q;
  assign cs_n = cs_n_q;
  assign sdo  = sdo_q;
  assign sat  = sat_q;
  assign ovf  = ovf_q;
  assign busy = (state_q != S_IDLE) | (cnt_q != '0);

endmodule
